// File: rtl/isu_issue_queue_if.sv
// Request/issue/refill/release bus of the issue queue.
// slave: the queue itself; master: the HTU / memctl / response-stage side.
interface isu_issue_queue_if #(
    parameter int WAY_IDX_W = 2,
    parameter int SET_W     = 6,
    parameter int OFFSET_W  = 4,
    parameter int WBUF_W    = 3
);
    localparam int ID_W = WAY_IDX_W + SET_W;

    logic                u_valid;
    logic                u_ready;
    logic                u_refill_valid;
    logic [2:0]          u_channel_1hot_id;
    logic [2:0]          u_op;
    logic [ID_W-1:0]     u_id;
    logic [OFFSET_W-1:0] u_offset;
    logic [WBUF_W-1:0]   u_wbuf_id;

    logic                refill_done_valid;
    logic [ID_W-1:0]     refill_done_id;

    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_channel_1hot_id;
    logic [2:0]          d_op;
    logic [ID_W-1:0]     d_id;
    logic [OFFSET_W-1:0] d_offset;
    logic [WBUF_W-1:0]   d_wbuf_id;
    logic                d_refilled;

    logic                ref_rel_valid;
    logic [ID_W-1:0]     ref_rel_id;

    modport slave (
        input  u_valid, u_refill_valid, u_channel_1hot_id, u_op, u_id, u_offset, u_wbuf_id,
        input  refill_done_valid, refill_done_id, d_ready,
        output u_ready, d_valid, d_channel_1hot_id, d_op, d_id, d_offset, d_wbuf_id, d_refilled,
        output ref_rel_valid, ref_rel_id
    );

    modport master (
        output u_valid, u_refill_valid, u_channel_1hot_id, u_op, u_id, u_offset, u_wbuf_id,
        output refill_done_valid, refill_done_id, d_ready,
        input  u_ready, d_valid, d_channel_1hot_id, d_op, d_id, d_offset, d_wbuf_id, d_refilled,
        input  ref_rel_valid, ref_rel_id
    );
endinterface

// File: rtl/isu_issue_queue.sv
// Compacting issue queue: holds misses until refill, issues oldest-issuable with per-line order.
// Optional same-cycle bypass into an empty queue: define ISQ_BYPASS_EN.
module isu_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int WAY_IDX_W = 2,
    parameter int SET_W     = 6,
    parameter int OFFSET_W  = 4,
    parameter int WBUF_W    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    isu_issue_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int ID_W  = WAY_IDX_W + SET_W;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [2:0]          ch;
        logic [2:0]          op;
        logic [ID_W-1:0]     id;
        logic [OFFSET_W-1:0] offset;
        logic [WBUF_W-1:0]   wbuf;
        logic                waiting;
        logic                refilled;
    } entry_t;

    entry_t             ent_q   [DEPTH];
    entry_t             ent_d   [DEPTH];
    entry_t             ent_clr [DEPTH+1];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   issuable;
    logic [IDX_W-1:0]   sel_idx;
    logic               any_issuable;
    logic               bypass;
    logic               deq;
    logic               enq;
    logic [CNT_W-1:0]   wr_idx;
    entry_t             sel_ent;
    entry_t             new_ent;

    // Valid entries are contiguous from 0, so index < count is the valid bit.
    always_comb begin
        issuable = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic older_same;
            older_same = 1'b0;
            for (int unsigned j = 0; j < i; j++) begin
                if (ent_q[j].id == ent_q[i].id) older_same = 1'b1;
            end
            issuable[i] = (CNT_W'(i) < count_q) && !ent_q[i].waiting && !older_same;
        end
    end

    always_comb begin
        any_issuable = 1'b0;
        sel_idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (issuable[i] && !any_issuable) begin
                any_issuable = 1'b1;
                sel_idx      = IDX_W'(i);
            end
        end
    end

    assign sel_ent = ent_q[sel_idx];

`ifdef ISQ_BYPASS_EN
    assign bypass = (count_q == '0) && bus.u_valid && !bus.u_refill_valid;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        bus.u_ready = (count_q < CNT_W'(DEPTH));
        bus.d_valid = any_issuable || bypass;
        if (bypass) begin
            bus.d_channel_1hot_id = bus.u_channel_1hot_id;
            bus.d_op              = bus.u_op;
            bus.d_id              = bus.u_id;
            bus.d_offset          = bus.u_offset;
            bus.d_wbuf_id         = bus.u_wbuf_id;
            bus.d_refilled        = 1'b0;
        end else begin
            bus.d_channel_1hot_id = sel_ent.ch;
            bus.d_op              = sel_ent.op;
            bus.d_id              = sel_ent.id;
            bus.d_offset          = sel_ent.offset;
            bus.d_wbuf_id         = sel_ent.wbuf;
            bus.d_refilled        = sel_ent.refilled;
        end
        bus.ref_rel_valid = bus.d_valid && bus.d_ready;
        bus.ref_rel_id    = bus.d_id;
    end

    always_comb begin
        new_ent.ch       = bus.u_channel_1hot_id;
        new_ent.op       = bus.u_op;
        new_ent.id       = bus.u_id;
        new_ent.offset   = bus.u_offset;
        new_ent.wbuf     = bus.u_wbuf_id;
        new_ent.waiting  = bus.u_refill_valid;
        new_ent.refilled = bus.u_refill_valid;
    end

    // A consumed bypass never enters storage; the queue is empty then, so deq is 0.
    assign deq     = any_issuable && bus.d_ready;
    assign enq     = bus.u_valid && bus.u_ready && !(bypass && bus.d_ready);
    assign wr_idx  = count_q - CNT_W'(deq);
    assign count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

    // Refill clears apply before the shift; the incoming entry is written afterwards
    // and therefore keeps its own wait bit.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_clr[i] = ent_q[i];
            if (bus.refill_done_valid && (ent_q[i].id == bus.refill_done_id)
                && (CNT_W'(i) < count_q)) begin
                ent_clr[i].waiting = 1'b0;
            end
        end
        ent_clr[DEPTH] = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = (deq && (IDX_W'(i) >= sel_idx)) ? ent_clr[i+1] : ent_clr[i];
            if (enq && (CNT_W'(i) == wr_idx)) ent_d[i] = new_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

    assign count = count_q;
endmodule

// File: tb/tb_isu_issue_queue.sv
// Self-checking bench for isu_issue_queue: directed scenarios plus randomized traffic
// against a queue-based reference model (bypass expectations follow ISQ_BYPASS_EN).
module tb_isu_issue_queue;
    localparam int DEPTH     = 8;
    localparam int WAY_IDX_W = 2;
    localparam int SET_W     = 6;
    localparam int OFFSET_W  = 4;
    localparam int WBUF_W    = 3;
    localparam int ID_W      = WAY_IDX_W + SET_W;
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int PW        = 1 + 3 + 3 + ID_W + OFFSET_W + WBUF_W + 1 + 1 + ID_W + 1 + CNT_W;

    typedef struct packed {
        logic [2:0]          ch;
        logic [2:0]          op;
        logic [ID_W-1:0]     id;
        logic [OFFSET_W-1:0] off;
        logic [WBUF_W-1:0]   wbuf;
        logic                wt;
        logic                rf;
    } ment_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] count;
    int               n_checks = 0;
    int               n_fail = 0;
    ment_t            mq[$];

    isu_issue_queue_if #(.WAY_IDX_W(WAY_IDX_W), .SET_W(SET_W), .OFFSET_W(OFFSET_W),
                         .WBUF_W(WBUF_W)) bus();

    isu_issue_queue #(.DEPTH(DEPTH), .WAY_IDX_W(WAY_IDX_W), .SET_W(SET_W),
                      .OFFSET_W(OFFSET_W), .WBUF_W(WBUF_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .count(count));

    always #5 clk = ~clk;

    // Oldest entry that is not waiting and has no older entry of the same line.
    function automatic void m_sel(output bit found, output int s);
        bit blk;
        found = 0;
        s = 0;
        for (int k = 0; k < mq.size(); k++) begin
            blk = 0;
            for (int j = 0; j < k; j++) if (mq[j].id == mq[k].id) blk = 1;
            if (!found && !mq[k].wt && !blk) begin
                found = 1;
                s = k;
            end
        end
    endfunction

    function automatic bit m_bypass();
`ifdef ISQ_BYPASS_EN
        return (mq.size() == 0) && bus.u_valid && !bus.u_refill_valid;
`else
        return 1'b0;
`endif
    endfunction

    function automatic ment_t m_req();
        ment_t e;
        e.ch = bus.u_channel_1hot_id; e.op = bus.u_op; e.id = bus.u_id;
        e.off = bus.u_offset; e.wbuf = bus.u_wbuf_id;
        e.wt = bus.u_refill_valid; e.rf = bus.u_refill_valid;
        return e;
    endfunction

    function automatic logic [PW-1:0] m_expect();
        bit f, byp, dv, rel;
        int s;
        ment_t e;
        m_sel(f, s);
        byp = m_bypass();
        e = '0;
        if (byp) begin
            e = m_req();
            e.rf = 1'b0;
        end else if (f) e = mq[s];
        dv  = f || byp;
        rel = dv && bus.d_ready;
        return {dv, e.ch, e.op, e.id, e.off, e.wbuf, e.rf, rel, rel ? e.id : '0,
                mq.size() < DEPTH, CNT_W'(mq.size())};
    endfunction

    function automatic logic [PW-1:0] dut_pack();
        logic v;
        v = bus.d_valid;
        return {v, v ? bus.d_channel_1hot_id : 3'd0, v ? bus.d_op : 3'd0,
                v ? bus.d_id : '0, v ? bus.d_offset : '0, v ? bus.d_wbuf_id : '0,
                v ? bus.d_refilled : 1'b0, bus.ref_rel_valid,
                bus.ref_rel_valid ? bus.ref_rel_id : '0, bus.u_ready, count};
    endfunction

    task automatic model_step();
        bit f, byp, dv;
        int s;
        ment_t e;
        if (!rst_n) begin
            mq.delete();
            return;
        end
        m_sel(f, s);
        byp = m_bypass();
        dv  = f || byp;
        e   = m_req();
        foreach (mq[k]) if (bus.refill_done_valid && mq[k].id == bus.refill_done_id) mq[k].wt = 0;
        if (dv && bus.d_ready && f) mq.delete(s);
        if (bus.u_valid && (mq.size() + ((dv && bus.d_ready && f) ? 1 : 0)) < DEPTH + 0
            && !(byp && bus.d_ready)) mq.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.u_valid = 0; bus.u_refill_valid = 0; bus.u_channel_1hot_id = 3'b001;
        bus.u_op = 0; bus.u_id = 0; bus.u_offset = 0; bus.u_wbuf_id = 0;
        bus.refill_done_valid = 0; bus.refill_done_id = 0; bus.d_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic push(input logic [ID_W-1:0] id, input bit miss, input logic [2:0] op,
                        input logic [OFFSET_W-1:0] off);
        bus.u_valid = 1; bus.u_refill_valid = miss; bus.u_id = id; bus.u_op = op;
        bus.u_offset = off; bus.u_wbuf_id = op; bus.u_channel_1hot_id = 3'b010;
        tick();
        bus.u_valid = 0; bus.u_refill_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_checks++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dvalid: got %b expected 0", bus.d_valid); end
        n_checks++; if (bus.u_ready !== 1'b1) begin n_fail++; $display("FAIL rst_uready: got %b expected 1", bus.u_ready); end
        n_checks++; if (bus.ref_rel_valid !== 1'b0) begin n_fail++; $display("FAIL rst_relvalid: got %b expected 0", bus.ref_rel_valid); end
        for (int k = 0; k < 5; k++) push(ID_W'(k), 1'b0, 3'd1, OFFSET_W'(k));
        n_checks++; if (count !== 5) begin n_fail++; $display("FAIL rst_fill5: got %0d expected 5", count); end
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", count); end
        n_checks++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_dvalid: got %b expected 0", bus.d_valid); end
        n_checks++; if (bus.u_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_uready: got %b expected 1", bus.u_ready); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 8; k++) push(ID_W'(k), 1'b0, 3'(k), OFFSET_W'(k + 3));
        n_checks++; if (count !== 8) begin n_fail++; $display("FAIL fill_count: got %0d expected 8", count); end
        n_checks++; if (bus.u_ready !== 1'b0) begin n_fail++; $display("FAIL fill_uready: got %b expected 0", bus.u_ready); end
        bus.u_valid = 1; bus.u_id = 8'h99; bus.u_offset = 4'hF; bus.u_op = 3'd7;
        for (int k = 0; k < 3; k++) tick();
        idle();
        n_checks++; if (count !== 8) begin n_fail++; $display("FAIL fill_held: got %0d expected 8", count); end
        bus.d_ready = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (bus.d_valid !== 1'b1 || bus.d_id !== ID_W'(k) || bus.d_offset !== OFFSET_W'(k + 3)) begin
                n_fail++;
                $display("FAIL fill_drain%0d: got v=%b id=%h off=%h expected v=1 id=%h off=%h",
                         k, bus.d_valid, bus.d_id, bus.d_offset, k, k + 3);
            end
            tick();
        end
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL fill_empty: got %0d expected 0", count); end
        idle();
    endtask

    task automatic test_same_line();
        do_reset();
        push(8'h25, 1'b1, 3'd1, 4'd1);
        push(8'h25, 1'b0, 3'd2, 4'd2);
        push(8'h11, 1'b0, 3'd3, 4'd3);
        bus.d_ready = 1;
        #1;
        n_checks++; if (bus.d_valid !== 1'b1 || bus.d_id !== 8'h11) begin n_fail++; $display("FAIL sl_first: got v=%b id=%h expected v=1 id=11", bus.d_valid, bus.d_id); end
        n_checks++; if (bus.ref_rel_valid !== 1'b1 || bus.ref_rel_id !== 8'h11) begin n_fail++; $display("FAIL sl_rel: got v=%b id=%h expected v=1 id=11", bus.ref_rel_valid, bus.ref_rel_id); end
        tick();
        n_checks++; if (bus.d_valid !== 1'b0 || count !== 2) begin n_fail++; $display("FAIL sl_blocked: got v=%b cnt=%0d expected v=0 cnt=2", bus.d_valid, count); end
        bus.refill_done_valid = 1; bus.refill_done_id = 8'h25;
        #1;
        n_checks++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL sl_refill_same_cycle: got %b expected 0", bus.d_valid); end
        tick();
        bus.refill_done_valid = 0;
        #1;
        n_checks++; if (bus.d_valid !== 1'b1 || bus.d_id !== 8'h25 || bus.d_refilled !== 1'b1 || bus.d_op !== 3'd1) begin
            n_fail++; $display("FAIL sl_miss_issue: got v=%b id=%h rf=%b op=%0d expected v=1 id=25 rf=1 op=1", bus.d_valid, bus.d_id, bus.d_refilled, bus.d_op); end
        tick();
        n_checks++; if (bus.d_valid !== 1'b1 || bus.d_id !== 8'h25 || bus.d_refilled !== 1'b0 || bus.d_op !== 3'd2) begin
            n_fail++; $display("FAIL sl_hit_issue: got v=%b id=%h rf=%b op=%0d expected v=1 id=25 rf=0 op=2", bus.d_valid, bus.d_id, bus.d_refilled, bus.d_op); end
        tick();
        n_checks++; if (bus.d_valid !== 1'b0 || count !== 0) begin n_fail++; $display("FAIL sl_done: got v=%b cnt=%0d expected v=0 cnt=0", bus.d_valid, count); end
        idle();
    endtask

    task automatic test_enq_issue();
        do_reset();
        for (int k = 1; k <= 3; k++) push(ID_W'(k), 1'b0, 3'd0, OFFSET_W'(k));
        n_checks++; if (count !== 3) begin n_fail++; $display("FAIL ei_count3: got %0d expected 3", count); end
        bus.u_valid = 1; bus.u_id = 8'd4; bus.u_offset = 4'd4; bus.d_ready = 1;
        #1;
        n_checks++; if (bus.d_id !== 8'd1 || bus.u_ready !== 1'b1) begin n_fail++; $display("FAIL ei_issue: got id=%h rdy=%b expected id=01 rdy=1", bus.d_id, bus.u_ready); end
        tick();
        idle();
        n_checks++; if (count !== 3) begin n_fail++; $display("FAIL ei_count_hold: got %0d expected 3", count); end
        bus.d_ready = 1;
        for (int k = 2; k <= 4; k++) begin
            #1;
            n_checks++;
            if (bus.d_id !== ID_W'(k) || bus.d_offset !== OFFSET_W'(k)) begin
                n_fail++; $display("FAIL ei_order%0d: got id=%h off=%h expected id=%h off=%h", k, bus.d_id, bus.d_offset, k, k);
            end
            tick();
        end
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL ei_empty: got %0d expected 0", count); end
        idle();
    endtask

    task automatic test_spurious();
        do_reset();
        bus.refill_done_valid = 1; bus.refill_done_id = 8'h3F;
        tick();
        n_checks++; if (count !== 0 || bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL sp_empty: got cnt=%0d v=%b expected cnt=0 v=0", count, bus.d_valid); end
        bus.refill_done_valid = 0;
        push(8'h10, 1'b1, 3'd5, 4'd6);
        bus.d_ready = 1; bus.refill_done_valid = 1; bus.refill_done_id = 8'h3F;
        tick();
        bus.refill_done_valid = 0;
        n_checks++; if (count !== 1 || bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL sp_nomatch: got cnt=%0d v=%b expected cnt=1 v=0", count, bus.d_valid); end
        bus.refill_done_valid = 1; bus.refill_done_id = 8'h10;
        tick();
        bus.refill_done_valid = 0;
        n_checks++; if (bus.d_valid !== 1'b1 || bus.d_id !== 8'h10) begin n_fail++; $display("FAIL sp_match: got v=%b id=%h expected v=1 id=10", bus.d_valid, bus.d_id); end
        tick();
        idle();
    endtask

    task automatic test_bypass();
        do_reset();
        bus.u_valid = 1; bus.u_id = 8'h04; bus.u_op = 3'd6; bus.d_ready = 1;
        #1;
`ifdef ISQ_BYPASS_EN
        n_checks++; if (bus.d_valid !== 1'b1 || bus.d_id !== 8'h04 || bus.d_refilled !== 1'b0) begin n_fail++; $display("FAIL byp_same_cycle: got v=%b id=%h rf=%b expected v=1 id=04 rf=0", bus.d_valid, bus.d_id, bus.d_refilled); end
        n_checks++; if (bus.ref_rel_valid !== 1'b1 || bus.ref_rel_id !== 8'h04) begin n_fail++; $display("FAIL byp_rel: got v=%b id=%h expected v=1 id=04", bus.ref_rel_valid, bus.ref_rel_id); end
        tick();
        idle();
        n_checks++; if (count !== 0 || bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL byp_consumed: got cnt=%0d v=%b expected cnt=0 v=0", count, bus.d_valid); end
`else
        n_checks++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL nobyp_same_cycle: got %b expected 0", bus.d_valid); end
        tick();
        idle();
        bus.d_ready = 1;
        #1;
        n_checks++; if (bus.d_valid !== 1'b1 || bus.d_id !== 8'h04 || count !== 1) begin n_fail++; $display("FAIL nobyp_next: got v=%b id=%h cnt=%0d expected v=1 id=04 cnt=1", bus.d_valid, bus.d_id, count); end
        tick();
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL nobyp_empty: got %0d expected 0", count); end
`endif
        idle();
    endtask

    task automatic test_random();
        logic [PW-1:0] exp_v, got_v;
        logic [ID_W-1:0] pend[$];
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.u_valid           = ($urandom_range(0, 99) < 60);
            bus.u_refill_valid    = bus.u_valid && ($urandom_range(0, 99) < 30);
            bus.u_id              = ID_W'($urandom_range(0, 4));
            bus.u_op              = 3'($urandom);
            bus.u_offset          = OFFSET_W'($urandom);
            bus.u_wbuf_id         = WBUF_W'($urandom);
            bus.u_channel_1hot_id = 3'b001 << $urandom_range(0, 2);
            bus.d_ready           = ($urandom_range(0, 99) < 70);
            pend.delete();
            foreach (mq[k]) if (mq[k].wt) pend.push_back(mq[k].id);
            bus.refill_done_valid = ($urandom_range(0, 99) < 25);
            if (pend.size() > 0 && $urandom_range(0, 3) != 0)
                bus.refill_done_id = pend[$urandom_range(0, pend.size() - 1)];
            else
                bus.refill_done_id = ID_W'($urandom_range(0, 7));
            if (bus.refill_done_valid && bus.u_refill_valid && bus.refill_done_id == bus.u_id)
                bus.u_refill_valid = 0;
            #1;
            exp_v = m_expect();
            got_v = dut_pack();
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: got %h expected %h", c, got_v, exp_v);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_same_line();
        test_enq_issue();
        test_spurious();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/isu_issue_queue.md
Name: isu_issue_queue

Overview:
- Issue queue directly downstream of the HTU pipeline. It accepts hit/miss-classified requests and holds misses until the memory controller reports the line refill complete.
- Issues requests to the data-array/response stage, oldest-issuable first, with strict per-line ordering.
- Returns a reference-counter release on every issue.

Parameters:
DEPTH, 8, queue entries (power of 2, >=2)
WAY_IDX_W, 2, way index width
SET_W, 6, set index width
OFFSET_W, 4, word offset width
WBUF_W, 3, write-buffer id width
ID_W, WAY_IDX_W+SET_W, line id width {way,set} (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
u_valid  in  1  request valid from HTU
u_ready  out  1  queue can accept
u_refill_valid  in  1  request is a miss; asserted only with u_valid
u_channel_1hot_id  in  3  requesting channel, one-hot
u_op  in  3  cache op
u_id  in  ID_W  line id {way,set}
u_offset  in  OFFSET_W  word offset
u_wbuf_id  in  WBUF_W  write-buffer id
refill_done_valid  in  1  memctl line refill complete
refill_done_id  in  ID_W  completed line id
d_valid  out  1  issue valid
d_ready  in  1  downstream accepts
d_channel_1hot_id  out  3  issued channel
d_op  out  3  issued op
d_id  out  ID_W  issued line id
d_offset  out  OFFSET_W  issued offset
d_wbuf_id  out  WBUF_W  issued wbuf id
d_refilled  out  1  issued entry was a miss
ref_rel_valid  out  1  reference-counter decrement strobe
ref_rel_id  out  ID_W  line to decrement
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Only clk is used. rst_n is sampled on the clk edge.
- Reset: count=0, all entry valid/wait bits 0. Hence d_valid=0, ref_rel_valid=0, u_ready=1. Payload registers are don't-care.
- Storage is a compacting shift queue. Index 0 is the oldest entry; valid entries are contiguous from 0.
- Each entry holds the fields {ch, op, id, offset, wbuf, wait, refilled}.
- Enqueue occurs when u_valid&u_ready.
  - The new entry is written at index count, or at index count-1 if an issue occurs in the same cycle.
  - wait = refilled = u_refill_valid.
- u_ready = (count < DEPTH). u_ready does not depend on a same-cycle issue, so a full queue refuses input even while it issues.
- An entry i is issuable when all of the following hold:
  - valid;
  - wait=0;
  - no older valid entry j<i has id==entry i id.
- The selected entry is the lowest-index issuable entry.
- d_valid = any issuable entry. d_* outputs are driven combinationally from the selected entry registers.
- Latency: a request enqueued in cycle N is issuable no earlier than cycle N+1.
- Issue occurs when d_valid&d_ready.
  - The selected entry is removed.
  - Entries above it shift down by one.
  - count decrements, unless an enqueue occurs in the same cycle, in which case count holds.
- d_* outputs must hold stable while d_valid&!d_ready, unless a refill_done makes an older same-line-free entry issuable. Downstream tolerates reselection.
- ref_rel_valid = d_valid&d_ready; ref_rel_id = d_id. Same cycle as the issue, with no register.
- refill_done_valid clears wait on every valid entry with id==refill_done_id that is not being enqueued this cycle. Cleared entries are issuable the next cycle.
- If refill_done arrives with no matching entry, it is ignored and no error is raised.
- Simultaneous enqueue of a miss and refill_done on the same id: the new entry keeps wait=1. The HTU reference counter guarantees this case does not occur legally.
- Simultaneous enqueue and issue when count==DEPTH: no enqueue occurs (u_ready=0).
- Hit requests to a line are ordered behind a waiting miss to the same line through the same-id rule.
- Hits to other lines bypass a waiting entry.
- Requests with u_refill_valid=0 never set wait.

Optional Feature:
ISQ_BYPASS_EN
- Defined: when count==0 and u_valid&!u_refill_valid, the request is presented on d_* in the same cycle.
  - d_refilled=0.
  - If d_ready, the request is consumed, not enqueued, and ref_rel fires.
  - If !d_ready, it is enqueued normally.
  - refill_done_valid has no effect on a bypassed request.
- Undefined: there is no combinational u->d path; the minimum latency is 1 cycle.

Test Plan:
- Reset mid-traffic: fill 5 entries, assert rst_n=0 for one edge -> next cycle count=0, d_valid=0, u_ready=1.
- Fill check: with d_ready=0, send 8 hits with ids 0..7 -> count=8, u_ready=0. The 9th request is held (u_valid=1 is not accepted) and no entry is overwritten.
- Same-line ordering: send a miss to id 0x25, then a hit to id 0x25, then a hit to id 0x11. d_ready=1 -> only 0x11 issues (ref_rel_id=0x11). Then drive refill_done_id=0x25 -> next cycle 0x25 miss issues with d_refilled=1, and the following cycle the 0x25 hit issues.
- Simultaneous enqueue+issue: count=3 with all issuable, assert d_ready=1 and u_valid=1 -> count stays 3. The new entry sits at index 2; index 0 issued and indices 1,2 shifted down.
- Spurious refill_done_id=0x3F with no matching entry -> no state change, no d_valid.
- ISQ_BYPASS_EN: empty queue, hit to id 0x04 with d_ready=1 -> d_valid and ref_rel_valid in the same cycle, count remains 0. Without the macro, the same stimulus -> d_valid one cycle later.
